// File: rtl/icache_pkg.sv
// Shared types, widths and address helpers for the instruction cache.
package icache_pkg;

  localparam int ADDR_W = 10;
  localparam int NUM_LINES = 8;
  localparam int WORDS_PER_LINE = 4;

  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int BLK_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  function automatic logic [OFFSET_W-1:0] get_offset(
    input logic [31:0] pc
  );
    return pc[2 +: OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(
    input logic [31:0] pc
  );
    return pc[2+OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(
    input logic [31:0] pc
  );
    return pc[2+OFFSET_W+INDEX_W +: TAG_W];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read, synchronous write,
// synchronous clear of all valid bits.
module icache_line_store
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [LINE_W-1:0]    data [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = data[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with single-line refill.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module instruction_cache
  import icache_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC_ADDRESS,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic [BLK_W-1:0]  MEM_ADDRESS,
  output logic              MEM_READ,
  input  logic [LINE_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       HIT_COUNT,
  output logic [15:0]       MISS_COUNT
`endif
);

  state_t state;
  state_t next;

  logic [OFFSET_W-1:0] pc_offset;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic [WORDS_PER_LINE-1:0][31:0] rd_words;

  logic [BLK_W-1:0]    blk_addr;
  logic [LINE_W-1:0]   line_buf;
  logic [31:0]         last_instr;
  logic [31:0]         hit_word;
  logic                hit;
  logic                idle;
  logic                idle_hit;
  logic                we;

  assign pc_offset = get_offset(PC_ADDRESS);
  assign pc_index  = get_index(PC_ADDRESS);
  assign pc_tag    = get_tag(PC_ADDRESS);

  icache_line_store u_store (
    .clk      (CLK),
    .rst      (RESET),
    .we       (we),
    .rd_index (pc_index),
    .wr_index (blk_addr[INDEX_W-1:0]),
    .wr_tag   (blk_addr[BLK_W-1 -: TAG_W]),
    .wr_line  (line_buf),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  assign rd_words = rd_line;
  assign hit_word = rd_words[pc_offset];
  assign hit      = rd_valid && (rd_tag == pc_tag);
  assign idle     = (state == S_IDLE);
  assign idle_hit = idle && hit;
  assign we       = (state == S_UPDATE) && !RESET;

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:     if (!hit) next = S_MEM_READ;
      S_MEM_READ: if (!MEM_BUSYWAIT) next = S_UPDATE;
      S_UPDATE:   next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Refill address is frozen at miss detection, not tracked from live PC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      blk_addr   <= '0;
      last_instr <= '0;
    end else begin
      state <= next;
      if (idle && !hit) blk_addr <= {pc_tag, pc_index};
      if (idle_hit) last_instr <= hit_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && state == S_MEM_READ && !MEM_BUSYWAIT) begin
      line_buf <= MEM_READDATA;
    end
  end

  assign INSTRUCTION = RESET ? 32'd0 : (idle_hit ? hit_word : last_instr);
  assign BUSYWAIT    = !RESET && !idle_hit;
  assign MEM_READ    = (state == S_MEM_READ);
  assign MEM_ADDRESS = blk_addr;

`ifdef ICACHE_STATS_EN
  logic [15:0] hits;
  logic [15:0] misses;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (idle_hit && hits != 16'hFFFF) hits <= hits + 16'd1;
      if (idle && !hit && misses != 16'hFFFF) misses <= misses + 16'd1;
    end
  end

  assign HIT_COUNT  = hits;
  assign MISS_COUNT = misses;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed + random fetch stimulus against a memory-contents reference
// model of the instruction cache.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC_ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic [5:0]   MEM_ADDRESS;
  logic         MEM_READ;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC_ADDRESS   (PC_ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READ     (MEM_READ),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference: 1 KiB of instruction words, which block each line holds,
  // the last delivered instruction and hit/miss tallies.
  logic [31:0] mem_words [256];
  int          line_blk [8];
  logic [31:0] last_m;
  int          hits_m;
  int          misses_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [5:0] b);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_words[{b, 2'(w)}];
    return l;
  endfunction

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] sat16(input int v);
    return (v > 65535) ? 32'hFFFF : 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) line_blk[i] = -1;
    last_m = 32'd0;
    hits_m = 0;
    misses_m = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic fetch(input logic [31:0] pc, input int lat);
    int blk;
    int idx;
    int stall;
    int mcnt;
    int exp_stall;
    bit hit;
    blk = int'(pc[9:4]);
    idx = blk % 8;
    hit = (line_blk[idx] == blk);
    exp_stall = hit ? 0 : lat + 2;
    PC_ADDRESS = pc;
    stall = 0;
    mcnt = 0;
    for (int c = 0; c < 64; c++) begin
      #3;
      if (!BUSYWAIT) break;
      stall++;
      chk("hold_instr", INSTRUCTION, last_m);
      if (MEM_READ && mcnt == 1)
        chk("mem_addr", 32'(MEM_ADDRESS), 32'(blk));
      @(posedge CLK);
      #1;
      if (MEM_READ) begin
        mcnt++;
        MEM_BUSYWAIT = (mcnt < lat);
        MEM_READDATA = MEM_BUSYWAIT ? junk() : line_of(MEM_ADDRESS);
      end else begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = junk();
      end
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("instr", INSTRUCTION, mem_words[pc[9:2]]);
    chk("no_mem_read", 32'(MEM_READ), 32'd0);
    line_blk[idx] = blk;
    last_m = mem_words[pc[9:2]];
    hits_m++;
    if (!hit) misses_m++;
    @(posedge CLK);
    #1;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = junk();
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    #3;
    chk("hit_count", 32'(HIT_COUNT), sat16(hits_m));
    chk("miss_count", 32'(MISS_COUNT), sat16(misses_m));
    @(posedge CLK);
    #1;
    hits_m++;
`endif
  endtask

  initial begin
    logic [31:0] pc;
    int blk;
    RESET = 1'b1;
    PC_ADDRESS = 32'd0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    mem_words[0] = 32'h11;
    mem_words[1] = 32'h22;
    mem_words[2] = 32'h33;
    mem_words[3] = 32'h44;
    model_reset();

    repeat (2) @(posedge CLK);
    #4;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_instr", INSTRUCTION, 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold miss, same-line hits, conflict, alias.
    fetch(32'h000, 5);
    fetch(32'h004, 1);
    fetch(32'h008, 1);
    fetch(32'h00C, 1);
    fetch(32'h080, 3);
    fetch(32'h000, 2);
    fetch(32'h400, 1);
    fetch(32'hFFFF_F406, 1);
    chk_stats();

    // Reset in the middle of a refill, with a late memory response.
    PC_ADDRESS = 32'h100;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    #3;
    chk("mid_mem_read", 32'(MEM_READ), 32'd1);
    chk("mid_busywait", 32'(BUSYWAIT), 32'd1);
    RESET = 1'b1;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = junk();
    #1;
    chk("mid_rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("mid_rst_instr", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    chk("mid_rst_mem_read", 32'(MEM_READ), 32'd0);
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b1;
    model_reset();
    fetch(32'h000, 3);
    fetch(32'h100, 2);
    fetch(32'h104, 1);
    chk_stats();

    // Random fetches over 32 blocks with random upper bits.
    for (int n = 0; n < 150; n++) begin
      blk = $urandom_range(0, 31);
      pc = ($urandom & 32'hFFFF_FC00) | 32'(blk << 4);
      pc = pc | 32'($urandom_range(0, 15));
      fetch(pc, $urandom_range(1, 4));
    end
    chk_stats();

`ifdef ICACHE_STATS_EN
    // Hold a hitting PC long enough to saturate the hit counter.
    repeat (70000) @(posedge CLK);
    hits_m += 70000;
    #1;
    chk_stats();
    fetch(PC_ADDRESS, 1);
    chk_stats();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
